// File: rtl/result_drain.sv
// Result drain: credit-issued output-buffer pops, per-lane round/shift/saturate, valid/ready row stream.
// A row reaches m_data OBUF_LAT+1 cycles after its out_en; issue stalls while FIFO rows plus in-flight rows fill FIFO_DEPTH.
module result_drain #(
  parameter int ARRAYWIDTH = 8,
  parameter int IN_W       = 32,
  parameter int OUT_W      = 8,
  parameter int OBUF_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  num_rows,
  input  logic [4:0]                  shift,
  output logic                        busy,
  output logic                        done,
  output logic                        out_en,
  input  logic [ARRAYWIDTH*IN_W-1:0]  out_res,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [ARRAYWIDTH*OUT_W-1:0] m_data,
  output logic                        m_last
);
  localparam int SW = IN_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                  state;
  logic [7:0]                  rows_q;
  logic [7:0]                  issued;
  logic [7:0]                  popped;
  logic [4:0]                  shift_q;
  logic                        done_q;
  logic [OBUF_LAT-1:0]         vld_pipe;
  logic                        capture;
  logic                        pop;
  logic                        fifo_vld;
  logic [CW-1:0]               fifo_count;
  logic [7:0]                  inflight;
  logic [7:0]                  credit_used;
  logic [ARRAYWIDTH*OUT_W-1:0] row_q;
  logic [ARRAYWIDTH*OUT_W-1:0] fifo_head;

  // Every issued row owns a FIFO slot from out_en until it is popped.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < OBUF_LAT; k++) begin
      inflight = inflight + 8'(vld_pipe[k]);
    end
  end

  assign credit_used = 8'(fifo_count) + inflight;
  assign out_en  = (state == DRAIN) && (issued < rows_q) && (credit_used < 8'(FIFO_DEPTH));
  assign capture = vld_pipe[OBUF_LAT-1];
  assign pop     = fifo_vld & m_ready;
  assign m_valid = fifo_vld;
  assign m_data  = fifo_vld ? fifo_head : '0;
  assign m_last  = fifo_vld && (popped == rows_q - 8'd1);
  assign busy    = (state == DRAIN);
  assign done    = done_q;

  if (OBUF_LAT == 1) begin : g_pipe1
    always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= out_en;
    end
  end else begin : g_pipen
    always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[OBUF_LAT-2:0], out_en};
    end
  end

  // Rounding add is done one bit wider than the lane so it cannot wrap.
  for (genvar i = 0; i < ARRAYWIDTH; i++) begin : g_lane
    logic signed [IN_W-1:0] x;
    logic signed [SW-1:0]   xe;
    logic signed [SW-1:0]   rnd;
    logic signed [SW-1:0]   sum;
    logic signed [SW-1:0]   y;

    assign x   = out_res[i*IN_W +: IN_W];
    assign xe  = {x[IN_W-1], x};
    assign rnd = (shift_q == 5'd0) ? '0 : (SW'(1) << (shift_q - 5'd1));
    assign sum = xe + rnd;
    assign y   = sum >>> shift_q;
    assign row_q[i*OUT_W +: OUT_W] = (y > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                                     (y < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : y[OUT_W-1:0];
  end

  sync_fifo #(
    .W     (ARRAYWIDTH*OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (capture),
    .wr_dat (row_q),
    .rd_vld (fifo_vld),
    .rd_rdy (m_ready),
    .rd_dat (fifo_head),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rows_q  <= '0;
      shift_q <= '0;
      issued  <= '0;
      popped  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            rows_q  <= num_rows;
            shift_q <= shift;
            issued  <= '0;
            popped  <= '0;
            state   <= (num_rows != 8'd0) ? DRAIN : DONE;
          end
        end
        DRAIN: begin
          if (out_en) issued <= issued + 8'd1;
          if (pop)    popped <= popped + 8'd1;
          if (pop && m_last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// Generic synchronous FIFO: write and read may happen in the same cycle.
// Head data is visible combinationally; the writer must not push when full.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_en;

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign rd_en  = rd_vld & rd_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_vld) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end
endmodule
